// File: rtl/hdmi_mode_sequencer.sv
// hdmi_mode_sequencer: frame-aligned, muted NTSC/PAL mode switch with encoder reset and settle.
// Optional SETTLE watchdog enabled by defining HDMI_SEQ_WATCHDOG_EN.
module hdmi_mode_sequencer #(
  parameter int MUTE_CYCLES    = 1024,
  parameter int RESET_CYCLES   = 16,
  parameter int SETTLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        pal_request,
  input  logic [11:0] cx,
  input  logic [10:0] cy,
  output logic        pal_mode,
  output logic        hdmi_reset,
  output logic        mute,
  output logic        busy,
  output logic        frame_start,
  output logic        timeout
);
  localparam int CMAX = MUTE_CYCLES > RESET_CYCLES ? MUTE_CYCLES : RESET_CYCLES;
  localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;
  localparam int FW   = $clog2(SETTLE_FRAMES + 1);
  typedef enum logic [2:0] {RUN, WAIT_FRAME, MUTE, HOLD_RESET, SETTLE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [FW-1:0] frames, frames_n;
  logic fs_raw, fs_raw_q, pal_mode_n, timeout_n, wd_exp;
  if (MUTE_CYCLES < 1 || RESET_CYCLES < 1 || SETTLE_FRAMES < 1 || TIMEOUT_CYCLES < 1)
    $error("hdmi_mode_sequencer: all cycle/frame parameters must be >= 1");
  assign fs_raw = cx == '0 && cy == '0;
`ifdef HDMI_SEQ_WATCHDOG_EN
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] wd, wd_n;
  assign wd_exp = wd == TW'(TIMEOUT_CYCLES - 1);
  // Runs only while staying in SETTLE, so every SETTLE entry starts from zero.
  assign wd_n = (state == SETTLE && state_n == SETTLE) ? wd + 1'b1 : '0;
  always_ff @(posedge clk_pixel) wd <= reset ? '0 : wd_n;
`else
  assign wd_exp = 1'b0;
`endif
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    frames_n   = frames;
    pal_mode_n = pal_mode;
    timeout_n  = 1'b0;
    case (state)
      RUN: state_n = pal_request != pal_mode ? WAIT_FRAME : RUN;
      WAIT_FRAME:
        if (pal_request == pal_mode) state_n = RUN;
        else if (frame_start) begin
          state_n = MUTE;
          cnt_n   = CW'(MUTE_CYCLES - 1);
        end
      MUTE:
        if (cnt == '0) begin
          state_n    = HOLD_RESET;
          pal_mode_n = pal_request;
          cnt_n      = CW'(RESET_CYCLES - 1);
        end else cnt_n = cnt - 1'b1;
      HOLD_RESET:
        if (cnt == '0) begin
          state_n  = SETTLE;
          frames_n = '0;
        end else cnt_n = cnt - 1'b1;
      SETTLE: begin
        frames_n = frame_start ? frames + 1'b1 : frames;
        if (frame_start && frames == FW'(SETTLE_FRAMES - 1)) state_n = RUN;
        else if (wd_exp) begin
          state_n   = RUN;
          timeout_n = 1'b1;
        end
      end
      default: state_n = HOLD_RESET;
    endcase
  end
  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state       <= HOLD_RESET;
      cnt         <= CW'(RESET_CYCLES - 1);
      frames      <= '0;
      pal_mode    <= 1'b0;
      fs_raw_q    <= 1'b0;
      frame_start <= 1'b0;
      timeout     <= 1'b0;
      hdmi_reset  <= 1'b1;
      mute        <= 1'b1;
      busy        <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      frames      <= frames_n;
      pal_mode    <= pal_mode_n;
      fs_raw_q    <= fs_raw;
      frame_start <= fs_raw && !fs_raw_q;
      timeout     <= timeout_n;
      hdmi_reset  <= state_n == HOLD_RESET;
      mute        <= state_n inside {MUTE, HOLD_RESET, SETTLE};
      busy        <= state_n != RUN;
    end
  end
endmodule

// File: tb/tb_hdmi_mode_sequencer.sv
// tb_hdmi_mode_sequencer: randomized frame timing checked against spec-derived phase lengths.
module tb_hdmi_mode_sequencer;
  localparam int M = 8, R = 4, S = 2, T = 100;
  logic clk_pixel = 1'b0, reset, pal_request;
  logic [11:0] cx;
  logic [10:0] cy;
  logic pal_mode, hdmi_reset, mute, busy, frame_start, timeout;
  int cyc, pos, flen, hold, fs_err, pm_err, to_err, n_checks, n_fail;
  logic raw, raw_q, exp_fs;

  hdmi_mode_sequencer #(.MUTE_CYCLES(M), .RESET_CYCLES(R), .SETTLE_FRAMES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk_pixel(clk_pixel), .reset(reset), .pal_request(pal_request), .cx(cx), .cy(cy),
    .pal_mode(pal_mode), .hdmi_reset(hdmi_reset), .mute(mute), .busy(busy),
    .frame_start(frame_start), .timeout(timeout));

  always #5 clk_pixel = ~clk_pixel;

  task automatic drive();
    cx  = hold == 1 ? 12'd0 : hold == 2 ? 12'd5 : 12'(pos);
    cy  = '0;
    raw = cx == 0 && cy == 0;
  endtask

  // One clock: sample 1 time unit after the edge, update the frame model, then drive new inputs.
  task automatic tick();
    logic pm0;
    pm0 = pal_mode;
    @(posedge clk_pixel);
    #1;
    cyc++;
    if (reset) begin
      exp_fs = 1'b0;
      raw_q  = 1'b0;
    end else begin
      exp_fs = raw && !raw_q;
      raw_q  = raw;
    end
    if (frame_start !== exp_fs) fs_err++;
    if (pal_mode !== pm0 && hdmi_reset !== 1'b1) pm_err++;
`ifndef HDMI_SEQ_WATCHDOG_EN
    if (timeout !== 1'b0) to_err++;
`endif
    if (hold == 0) pos = (pos + 1) % flen;
    drive();
  endtask

  task automatic new_frame_timing();
    flen = $urandom_range(60, 250);
    pos  = $urandom_range(0, flen - 1);
    drive();
  endtask

  // Walks one mode-change sequence and reports phase lengths; comparisons are made by the callers.
  task automatic measure_seq(input bit from_wait, input bit flip_in_rst, input bit stop_settle,
                             output int wait_bad, output int mute_len, output logic mode_at_rst,
                             output int rst_len, output int fs_seen, output int gap);
    int n, last;
    logic m0;
    wait_bad = 0; mute_len = 0; rst_len = 0; fs_seen = 0; gap = -1; mode_at_rst = 1'bx;
    m0 = pal_mode;
    if (from_wait) begin
      n = 0;
      while (!exp_fs && n < 5000) begin
        if (mute !== 1'b0 || hdmi_reset !== 1'b0 || pal_mode !== m0 || busy !== 1'b1) wait_bad++;
        tick(); n++;
      end
      if (n >= 5000) begin
        wait_bad++;
        return;
      end
      tick();
      n = 0;
      while (mute === 1'b1 && hdmi_reset === 1'b0 && n < 5000) begin mute_len++; tick(); n++; end
    end
    mode_at_rst = pal_mode;
    if (flip_in_rst) pal_request = !pal_request;
    n = 0;
    while (hdmi_reset === 1'b1 && mute === 1'b1 && n < 5000) begin rst_len++; tick(); n++; end
    if (stop_settle) return;
    last = -1;
    n = 0;
    while (mute === 1'b1 && n < 5000) begin
      if (exp_fs) begin fs_seen++; last = cyc; end
      tick(); n++;
    end
    gap = (last < 0 || mute !== 1'b0) ? -1 : cyc - last;
  endtask

  task automatic test_reset();
    reset = 1'b1; pal_request = 1'b0; hold = 0;
    new_frame_timing();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if ({pal_mode, hdmi_reset, mute, busy, frame_start, timeout} !== 6'b011100) begin n_fail++; $display("FAIL reset_values cycle %0d got=%b exp=011100", i, {pal_mode, hdmi_reset, mute, busy, frame_start, timeout}); end
    end
    reset = 1'b0;
  endtask

  task automatic test_boot();
    int wb, ml, rl, fs, gp;
    logic mr;
    measure_seq(0, 0, 0, wb, ml, mr, rl, fs, gp);
    n_checks++; if (rl !== R) begin n_fail++; $display("FAIL boot_rst_len got=%0d exp=%0d", rl, R); end
    n_checks++; if (fs !== S) begin n_fail++; $display("FAIL boot_settle_frames got=%0d exp=%0d", fs, S); end
    n_checks++; if (gp !== 1) begin n_fail++; $display("FAIL boot_unmute_gap got=%0d exp=1", gp); end
    n_checks++; if ({busy, pal_mode} !== 2'b00) begin n_fail++; $display("FAIL boot_run got busy,pal_mode=%b exp=00", {busy, pal_mode}); end
  endtask

  task automatic test_cancel();
    int bad;
    logic m;
    m = pal_mode; bad = 0;
    new_frame_timing();
    pos = 1; drive();
    pal_request = !m;
    tick();
    n_checks++; if ({busy, mute} !== 2'b10) begin n_fail++; $display("FAIL cancel_wait got busy,mute=%b exp=10", {busy, mute}); end
    for (int i = 0; i < int'($urandom_range(1, 20)); i++) begin
      if (mute !== 1'b0 || hdmi_reset !== 1'b0 || pal_mode !== m) bad++;
      tick();
    end
    pal_request = m;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_return got busy=%b exp=0", busy); end
    for (int i = 0; i < 2 * flen; i++) begin
      if (mute !== 1'b0 || hdmi_reset !== 1'b0 || pal_mode !== m || busy !== 1'b0) bad++;
      tick();
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL cancel_outputs_stable got=%0d changed cycles exp=0", bad); end
  endtask

  task automatic test_mode_change(input logic to);
    int wb, ml, rl, fs, gp;
    logic mr;
    new_frame_timing();
    pal_request = to;
    tick();
    n_checks++; if ({busy, mute} !== 2'b10) begin n_fail++; $display("FAIL change%0d_wait got busy,mute=%b exp=10", to, {busy, mute}); end
    measure_seq(1, 0, 0, wb, ml, mr, rl, fs, gp);
    n_checks++; if (wb !== 0) begin n_fail++; $display("FAIL change%0d_wait_outputs got=%0d bad exp=0", to, wb); end
    n_checks++; if (ml !== M) begin n_fail++; $display("FAIL change%0d_mute_len got=%0d exp=%0d", to, ml, M); end
    n_checks++; if (mr !== to) begin n_fail++; $display("FAIL change%0d_mode_at_reset got=%b exp=%b", to, mr, to); end
    n_checks++; if (rl !== R) begin n_fail++; $display("FAIL change%0d_rst_len got=%0d exp=%0d", to, rl, R); end
    n_checks++; if (fs !== S) begin n_fail++; $display("FAIL change%0d_settle_frames got=%0d exp=%0d", to, fs, S); end
    n_checks++; if (gp !== 1) begin n_fail++; $display("FAIL change%0d_unmute_gap got=%0d exp=1", to, gp); end
    n_checks++; if ({busy, pal_mode} !== {1'b0, to}) begin n_fail++; $display("FAIL change%0d_run got busy,pal_mode=%b exp=%b", to, {busy, pal_mode}, {1'b0, to}); end
  endtask

  task automatic test_late_request();
    int wb, ml, rl, fs, gp;
    logic mr, m;
    m = pal_mode;
    new_frame_timing();
    pal_request = !m;
    tick();
    measure_seq(1, 1, 0, wb, ml, mr, rl, fs, gp);
    n_checks++; if (mr !== !m) begin n_fail++; $display("FAIL late_first_mode got=%b exp=%b", mr, !m); end
    n_checks++; if (rl !== R || fs !== S || gp !== 1) begin n_fail++; $display("FAIL late_first_seq got rst=%0d fs=%0d gap=%0d exp rst=%0d fs=%0d gap=1", rl, fs, gp, R, S); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL late_idle_run got busy=%b exp=0", busy); end
    tick();
    n_checks++; if ({busy, mute} !== 2'b10) begin n_fail++; $display("FAIL late_second_wait got busy,mute=%b exp=10", {busy, mute}); end
    measure_seq(1, 0, 0, wb, ml, mr, rl, fs, gp);
    n_checks++; if (mr !== m || ml !== M) begin n_fail++; $display("FAIL late_second_seq got mode=%b mute_len=%0d exp mode=%b mute_len=%0d", mr, ml, m, M); end
    n_checks++; if (pal_mode !== m) begin n_fail++; $display("FAIL late_final_mode got=%b exp=%b", pal_mode, m); end
  endtask

  task automatic test_frame_hold();
    int pulses;
    pulses = 0;
    pos = 1; drive();
    tick(); tick();
    hold = 1; drive();
    for (int i = 0; i < int'($urandom_range(5, 20)); i++) begin
      tick();
      if (frame_start === 1'b1) pulses++;
    end
    hold = 0; pos = 1; drive();
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL frame_hold_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_reset_mid_settle();
    int wb, ml, rl, fs, gp;
    logic mr;
    new_frame_timing();
    pal_request = 1'b1;
    tick();
    measure_seq(1, 0, 1, wb, ml, mr, rl, fs, gp);
    n_checks++; if ({pal_mode, hdmi_reset, mute} !== 3'b101) begin n_fail++; $display("FAIL settle_entry got pal_mode,hdmi_reset,mute=%b exp=101", {pal_mode, hdmi_reset, mute}); end
    reset = 1'b1; pal_request = 1'b0;
    tick();
    n_checks++; if ({pal_mode, hdmi_reset, mute, busy} !== 4'b0111) begin n_fail++; $display("FAIL mid_reset_values got=%b exp=0111", {pal_mode, hdmi_reset, mute, busy}); end
    reset = 1'b0;
    measure_seq(0, 0, 0, wb, ml, mr, rl, fs, gp);
    n_checks++; if (rl !== R || fs !== S || gp !== 1) begin n_fail++; $display("FAIL reboot_seq got rst=%0d fs=%0d gap=%0d exp rst=%0d fs=%0d gap=1", rl, fs, gp, R, S); end
    n_checks++; if ({busy, pal_mode} !== 2'b00) begin n_fail++; $display("FAIL reboot_run got busy,pal_mode=%b exp=00", {busy, pal_mode}); end
  endtask

  task automatic test_watchdog();
    int wb, ml, rl, fs, gp, k;
    logic mr;
    new_frame_timing();
    pal_request = !pal_mode;
    tick();
    measure_seq(1, 0, 1, wb, ml, mr, rl, fs, gp);
    hold = 2; drive();
`ifdef HDMI_SEQ_WATCHDOG_EN
    k = 0;
    while (timeout !== 1'b1 && k < 1000) begin tick(); k++; end
    n_checks++; if (k !== T) begin n_fail++; $display("FAIL watchdog_latency got=%0d exp=%0d", k, T); end
    n_checks++; if (mute !== 1'b0) begin n_fail++; $display("FAIL watchdog_unmute got mute=%b exp=0", mute); end
    tick();
    n_checks++; if ({timeout, mute} !== 2'b00) begin n_fail++; $display("FAIL watchdog_pulse_width got timeout,mute=%b exp=00", {timeout, mute}); end
`else
    k = 0;
    for (int i = 0; i < 3 * T; i++) begin
      tick();
      if (mute !== 1'b1 || timeout !== 1'b0) k++;
    end
    n_checks++; if (k !== 0) begin n_fail++; $display("FAIL no_watchdog_hold got=%0d bad cycles exp=0", k); end
`endif
    hold = 0; drive();
  endtask

  task automatic test_invariants();
    n_checks++; if (fs_err !== 0) begin n_fail++; $display("FAIL frame_start_model got=%0d mismatching cycles exp=0", fs_err); end
    n_checks++; if (pm_err !== 0) begin n_fail++; $display("FAIL pal_mode_outside_reset got=%0d exp=0", pm_err); end
    n_checks++; if (to_err !== 0) begin n_fail++; $display("FAIL timeout_tied_low got=%0d exp=0", to_err); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    cyc = 0; fs_err = 0; pm_err = 0; to_err = 0; n_checks = 0; n_fail = 0;
    raw_q = 1'b0; exp_fs = 1'b0;
    test_reset();
    test_boot();
    test_cancel();
    test_late_request();
    test_mode_change(1'b1);
    test_mode_change(1'b0);
    test_frame_hold();
    test_reset_mid_settle();
    test_watchdog();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hdmi_mode_sequencer.md
Name: hdmi_mode_sequencer

Overview:
Controller that sequences NTSC/PAL output-mode changes for the dual-timing HDMI output path. It owns the `pal_mode` select and the `hdmi_reset` line that drive the NTSC/PAL HDMI encoders and the TMDS serializer diplexer. A requested mode change is applied only at a frame boundary, behind a mute window. The encoders are then held in reset and allowed to settle for N frames before the output is unmuted. Runs in the pixel clock domain and consumes the `cx`/`cy` counters fed back from the selected encoder.

Parameters:
MUTE_CYCLES, 1024, clk_pixel cycles that `mute` is held before `hdmi_reset` asserts (>=1)
RESET_CYCLES, 16, clk_pixel cycles that `hdmi_reset` is held high per sequence (>=1)
SETTLE_FRAMES, 2, frame_start pulses counted after reset release before unmute (>=1)
TIMEOUT_CYCLES, 2000000, watchdog limit in SETTLE (used only with the watchdog feature)

Ports:
clk_pixel  in  1  pixel clock; the only clock
reset  in  1  synchronous, active-high reset
pal_request  in  1  requested mode: 1 = PAL, 0 = NTSC; synchronous to clk_pixel
cx  in  12  current pixel column of the selected encoder
cy  in  11  current line of the selected encoder
pal_mode  out  1  applied mode select to the encoders and diplexer
hdmi_reset  out  1  reset to both HDMI encoders
mute  out  1  blank video/audio request to upstream
busy  out  1  high whenever state != RUN
frame_start  out  1  one-cycle pulse per frame
timeout  out  1  one-cycle pulse on watchdog expiry; constant 0 without the feature

Behaviour:
- Interface: one clock, `clk_pixel`. `reset` is synchronous and active-high; all outputs are registered.
- Reset values: `pal_mode`=0, `hdmi_reset`=1, `mute`=1, `busy`=1, `frame_start`=0, `timeout`=0.
- After reset, state=HOLD_RESET with target=0 (boot sequence).
- frame_start:
  - fs_raw = (cx==0 && cy==0).
  - `frame_start` <= fs_raw && !fs_raw_q, where fs_raw_q is fs_raw delayed one cycle.
  - Latency is 1 cycle after (0,0) is presented. It pulses at most once per frame, even if (0,0) is held.
- State RUN: `mute`=0, `hdmi_reset`=0, `busy`=0.
  - If `pal_request` != `pal_mode`, go to WAIT_FRAME next cycle.
- State WAIT_FRAME: `busy`=1, `mute`=0.
  - If `pal_request` == `pal_mode`, abort to RUN (cancel).
  - Else, on `frame_start`, go to MUTE and load the counter with MUTE_CYCLES-1. Cancel takes priority over `frame_start` in the same cycle.
- State MUTE: `mute`=1. The sequence is committed here; `pal_request` changes are ignored.
  - Stay exactly MUTE_CYCLES cycles.
  - On the last cycle, latch target <= `pal_request` and go to HOLD_RESET.
- State HOLD_RESET: `hdmi_reset`=1, `mute`=1, `pal_mode` <= target (updated on the entry edge).
  - `hdmi_reset` is high for exactly RESET_CYCLES cycles, counted from entry or from the first cycle after reset deasserts.
  - Then go to SETTLE and clear the frame counter.
- State SETTLE: `hdmi_reset`=0, `mute`=1.
  - Count `frame_start` pulses. When the count reaches SETTLE_FRAMES, go to RUN next cycle; `mute` falls on that RUN cycle.
- Requests during MUTE/HOLD_RESET/SETTLE are not lost. On return to RUN, any mismatch between `pal_request` and `pal_mode` starts a new sequence one cycle later.
- `pal_mode` changes only on the HOLD_RESET entry edge (or by reset). It is never toggled while `hdmi_reset`=0.
- Reset mid-operation: any state returns to the reset values and boot sequence on the next edge. Counters clear and target=0.
- Counter widths sized with $clog2 of the largest parameter. No wrap: counters saturate/reload only on state transitions.

Optional Feature:
HDMI_SEQ_WATCHDOG_EN:
- Defined: a cycle counter runs in SETTLE. If TIMEOUT_CYCLES elapse without reaching SETTLE_FRAMES, then:
  - pulse `timeout` for 1 cycle;
  - go to RUN (unmute anyway);
  - on the next cycle, re-evaluate any pending mismatch as normal.
  - The counter clears on every SETTLE entry.
- Undefined: no counter is built; SETTLE waits indefinitely and `timeout` is tied to 0.

Test Plan:
1. Boot:
   - Stimulus: reset for 3 cycles, `pal_request`=0, then one frame_start per 1000 cycles, with MUTE_CYCLES=8, RESET_CYCLES=4, SETTLE_FRAMES=2.
   - Required: `hdmi_reset` high for 4 cycles after release; `mute` falls on the cycle after the 2nd frame_start; `busy`=0; `pal_mode`=0.
2. NTSC->PAL:
   - Stimulus: in RUN, set `pal_request`=1.
   - Required: WAIT_FRAME until (cx,cy)=(0,0); `mute`=1 for 8 cycles with `hdmi_reset`=0; then `pal_mode`=1 and `hdmi_reset`=1 on the same edge for 4 cycles; unmute after 2 frames.
3. Cancel:
   - Stimulus: `pal_request` 0->1, then back to 0 before any frame_start.
   - Required: return to RUN; `mute`, `hdmi_reset` and `pal_mode` never change.
4. Late request:
   - Stimulus: `pal_request` set to 1, then to 0 during HOLD_RESET.
   - Required: `pal_mode` settles to 1; after unmute, one idle RUN cycle, then a second sequence returns `pal_mode` to 0.
5. Reset mid-SETTLE:
   - Stimulus: assert `reset` for 1 cycle while in SETTLE with `pal_mode`=1.
   - Required: next cycle `pal_mode`=0, `hdmi_reset`=1, `mute`=1, `busy`=1; the boot sequence follows.
6. Watchdog (HDMI_SEQ_WATCHDOG_EN, TIMEOUT_CYCLES=100):
   - Stimulus: hold cx=5 in SETTLE.
   - Required: a `timeout` pulse at 100 cycles and `mute`=0 next cycle. Without the macro, `mute` stays 1 indefinitely.
